timer_ctrl_master: RTL and testbench

Avalon-MM master that drives the 16-bit-data, 3-bit-address interval-timer slave on the DE4 sweep-trigger path. It converts simple user commands (arm with period, stop, snapshot) into timer register writes and reads. It services the timer IRQ by clearing the timeout status and emitting one tick pulse per timeout, which the A-line acquisition logic uses as its sweep-rate strobe. It owns the timer slave exclusively; no arbitration is required.

---
 rtl/timer_regs_pkg.sv | 51 +++++
 rtl/timer_ctrl_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_timer_ctrl_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_regs_pkg.sv
// Register map, control-bit positions and FSM encodings shared by the
// interval-timer master and anything that needs to decode its bus traffic.
package timer_regs_pkg;

  localparam logic [2:0] STATUS   = 3'd0;
  localparam logic [2:0] CONTROL  = 3'd1;
  localparam logic [2:0] PERIOD_L = 3'd2;
  localparam logic [2:0] PERIOD_H = 3'd3;
  localparam logic [2:0] SNAP_L   = 3'd4;
  localparam logic [2:0] SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    WR_STOP,
    WR_STAT,
    IRQ_SETTLE,
    SNAP_WR,
    SNAP_RDL,
    SNAP_CAPL,
    SNAP_CAPH
  } state_t;

  // Command accepted in RUN but parked behind a simultaneous IRQ service.
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_STOP,
    PEND_ARM,
    PEND_SNAP
  } pend_t;

  function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                            input logic cont);
    logic [15:0] w;
    w = '0;
    w[CTRL_ITO]   = start;
    w[CTRL_CONT]  = start & cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master for the sweep-trigger interval timer: turns arm/stop/snap
// commands into register accesses and converts timer IRQs into tick pulses.
//
// state      | meaning
// IDLE       | timer stopped, accepting commands
// WR_PL      | writing period low half
// WR_PH      | writing period high half
// WR_CTRL    | writing control with START (+CONT)
// RUN        | timer running, watching av_irq and commands
// WR_STOP    | writing control with STOP
// WR_STAT    | clearing timeout status; tick emitted here
// IRQ_SETTLE | bus idle while the slave drops its irq
// SNAP_WR    | write to snap_l latches the live count
// SNAP_RDL   | read address snap_l presented
// SNAP_CAPL  | capture low half, read address snap_h presented
// SNAP_CAPH  | capture high half, publish snapshot
module timer_ctrl_master
  import timer_regs_pkg::*;
#(
  parameter int TICK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_arm,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  input  logic                  cmd_stop,
  input  logic                  cmd_snap,
  output logic                  ready,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic [31:0]           snap_elapsed,
  output logic [2:0]            av_address,
  output logic                  av_chipselect,
  output logic                  av_write_n,
  output logic [15:0]           av_writedata,
  input  logic [15:0]           av_readdata,
  input  logic                  av_irq
);

  state_t      state, state_next;
  state_t      ret_state, ret_next;
  pend_t       pend, pend_next;
  logic [31:0] period_reg, pend_period, arm_period;
  logic        cont_reg, pend_cont, arm_cont;
  logic        load_arm, hold_arm;
  logic [15:0] snap_lo;
  logic [31:0] snap_word;
  logic        bus_cs, bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_data;

  assign snap_word = {av_readdata, snap_lo};

  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    pend_next  = pend;
    load_arm   = 1'b0;
    hold_arm   = 1'b0;
    arm_period = cmd_period;
    arm_cont   = cmd_continuous;
    case (state)
      IDLE: begin
        if (cmd_stop) begin
          state_next = WR_STOP;
        end else if (cmd_arm) begin
          state_next = WR_PL;
          load_arm   = 1'b1;
        end else if (cmd_snap) begin
          state_next = SNAP_WR;
          ret_next   = IDLE;
        end
      end
      RUN: begin
        if (av_irq) begin
          state_next = WR_STAT;
          if (cmd_stop) begin
            pend_next = PEND_STOP;
          end else if (cmd_arm) begin
            pend_next = PEND_ARM;
            hold_arm  = 1'b1;
          end else if (cmd_snap) begin
            pend_next = PEND_SNAP;
          end
        end else if (cmd_stop) begin
          state_next = WR_STOP;
        end else if (cmd_arm) begin
          state_next = WR_PL;
          load_arm   = 1'b1;
        end else if (cmd_snap) begin
          state_next = SNAP_WR;
          ret_next   = RUN;
        end
      end
      WR_PL:   state_next = WR_PH;
      WR_PH:   state_next = WR_CTRL;
      WR_CTRL: state_next = RUN;
      WR_STOP: state_next = IDLE;
      WR_STAT: state_next = IRQ_SETTLE;
      IRQ_SETTLE: begin
        pend_next = PEND_NONE;
        case (pend)
          PEND_STOP: state_next = WR_STOP;
          PEND_ARM: begin
            state_next = WR_PL;
            load_arm   = 1'b1;
            arm_period = pend_period;
            arm_cont   = pend_cont;
          end
          PEND_SNAP: begin
            state_next = SNAP_WR;
            ret_next   = cont_reg ? RUN : IDLE;
          end
          default: state_next = cont_reg ? RUN : IDLE;
        endcase
      end
      SNAP_WR:   state_next = SNAP_RDL;
      SNAP_RDL:  state_next = SNAP_CAPL;
      SNAP_CAPL: state_next = SNAP_CAPH;
      SNAP_CAPH: state_next = ret_state;
      default:   state_next = IDLE;
    endcase
  end

  // Bus access for the upcoming state, registered so the access lines up with it.
  always_comb begin
    bus_cs   = 1'b0;
    bus_wn   = 1'b1;
    bus_addr = STATUS;
    bus_data = '0;
    case (state_next)
      WR_PL: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = PERIOD_L;
        bus_data = arm_period[15:0];
      end
      WR_PH: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = PERIOD_H;
        bus_data = period_reg[31:16];
      end
      WR_CTRL: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = CONTROL;
        bus_data = ctrl_word(1'b1, 1'b0, cont_reg);
      end
      WR_STOP: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = CONTROL;
        bus_data = ctrl_word(1'b0, 1'b1, 1'b0);
      end
      WR_STAT: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = STATUS;
      end
      SNAP_WR: begin
        bus_cs   = 1'b1;
        bus_wn   = 1'b0;
        bus_addr = SNAP_L;
      end
      SNAP_RDL: begin
        bus_cs   = 1'b1;
        bus_addr = SNAP_L;
      end
      SNAP_CAPL: begin
        bus_cs   = 1'b1;
        bus_addr = SNAP_H;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ret_state     <= IDLE;
      pend          <= PEND_NONE;
      period_reg    <= '0;
      cont_reg      <= 1'b0;
      pend_period   <= '0;
      pend_cont     <= 1'b0;
      ready         <= 1'b1;
      running       <= 1'b0;
      tick          <= 1'b0;
      tick_count    <= '0;
      snap_lo       <= '0;
      snap_valid    <= 1'b0;
      snap_value    <= '0;
      snap_elapsed  <= '0;
      av_address    <= '0;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_writedata  <= '0;
    end else begin
      state         <= state_next;
      ret_state     <= ret_next;
      pend          <= pend_next;
      av_address    <= bus_addr;
      av_chipselect <= bus_cs;
      av_write_n    <= bus_wn;
      av_writedata  <= bus_data;
      ready         <= (state_next == IDLE) || (state_next == RUN);
      tick          <= (state_next == WR_STAT);

      if (load_arm) begin
        period_reg <= arm_period;
        cont_reg   <= arm_cont;
      end
      if (hold_arm) begin
        pend_period <= cmd_period;
        pend_cont   <= cmd_continuous;
      end

      if (load_arm)
        tick_count <= '0;
      else if (state_next == WR_STAT)
        tick_count <= tick_count + TICK_CNT_W'(1);

      if (state == WR_CTRL)
        running <= 1'b1;
      else if ((state_next == WR_STOP) || (state_next == WR_STAT && !cont_reg))
        running <= 1'b0;

      snap_valid <= 1'b0;
      if (state == SNAP_CAPL)
        snap_lo <= av_readdata;
      if (state == SNAP_CAPH) begin
        snap_value   <= snap_word;
        snap_elapsed <= period_reg - snap_word;
        snap_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: behavioural interval-timer slave, bus-write
// scoreboard, arm-vector table and hand-written IRQ/snap/stop/reset sequences.
module tb_timer_ctrl_master;
  import timer_regs_pkg::*;

  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_arm = 1'b0;
  logic [31:0]   cmd_period = '0;
  logic          cmd_continuous = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          cmd_snap = 1'b0;
  logic          ready, running, tick, snap_valid;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value, snap_elapsed;
  logic [2:0]    av_address;
  logic          av_chipselect, av_write_n;
  logic [15:0]   av_writedata;
  logic [15:0]   av_readdata;
  logic          av_irq;

  timer_ctrl_master #(.TICK_CNT_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_arm(cmd_arm), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .ready(ready), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_valid(snap_valid), .snap_value(snap_value), .snap_elapsed(snap_elapsed),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .av_irq(av_irq)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Interval-timer slave model: counts period..0, sets TO at zero and reloads.
  logic [31:0] t_period, t_count, t_snap;
  logic        t_run, t_to, t_ito, t_cont;

  assign av_irq = t_to & t_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_period <= '0; t_count <= '0; t_snap <= '0;
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      av_readdata <= '0;
    end else begin
      if (t_run) begin
        if (t_count == 0) begin
          t_to    <= 1'b1;
          t_count <= t_period;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_count <= t_count - 1;
        end
      end
      if (av_chipselect && !av_write_n) begin
        case (av_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= av_writedata[0];
            t_cont <= av_writedata[1];
            if (av_writedata[3]) t_run <= 1'b0;
            else if (av_writedata[2]) begin
              t_run   <= 1'b1;
              t_count <= t_period;
            end
          end
          3'd2: begin t_period[15:0]  <= av_writedata; t_run <= 1'b0; end
          3'd3: begin t_period[31:16] <= av_writedata; t_run <= 1'b0; end
          3'd4, 3'd5: t_snap <= t_count;
          default: ;
        endcase
      end
      if (av_chipselect && av_write_n) begin
        case (av_address)
          3'd0: av_readdata <= {14'd0, t_run, t_to};
          3'd2: av_readdata <= t_period[15:0];
          3'd3: av_readdata <= t_period[31:16];
          3'd4: av_readdata <= t_snap[15:0];
          3'd5: av_readdata <= t_snap[31:16];
          default: av_readdata <= '0;
        endcase
      end else begin
        av_readdata <= '0;
      end
    end
  end

  // Scoreboard of expected bus writes; cyc < 0 means timing not checked.
  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_exp_t;
  bus_exp_t exp_q[$];

  task automatic push_wr(input int cyc, input logic [2:0] addr, input logic [15:0] data);
    bus_exp_t e;
    e.cyc = cyc; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && av_chipselect && !av_write_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bus_unexpected: write addr %0d data 0x%0h at cycle %0d, none required",
                 av_address, av_writedata, cyc_n);
      end else begin
        bus_exp_t e;
        e = exp_q.pop_front();
        check("bus_addr", 32'(av_address), 32'(e.addr));
        check("bus_data", 32'(av_writedata), 32'(e.data));
        if (e.cyc >= 0) check("bus_cycle", cyc_n, e.cyc);
      end
    end
  end

  int tick_q[$];
  int snap_cyc = -1;
  int snap_seen = 0;
  always @(negedge clk) begin
    if (reset_n && tick) tick_q.push_back(cyc_n);
    if (reset_n && snap_valid) begin
      snap_cyc = cyc_n;
      snap_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [31:0] p, input logic c, input logic [15:0] pl,
                        input logic [15:0] ph, input logic [15:0] ctl, output int c0);
    c0 = cyc_n;
    cmd_arm = 1'b1; cmd_period = p; cmd_continuous = c;
    push_wr(c0 + 1, PERIOD_L, pl);
    push_wr(c0 + 2, PERIOD_H, ph);
    push_wr(c0 + 3, CONTROL, ctl);
    step(1);
    cmd_arm = 1'b0;
  endtask

  task automatic do_stop();
    push_wr(cyc_n + 1, CONTROL, 16'h0008);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
  endtask

  typedef struct {
    logic [31:0] period;
    logic        cont;
    logic [15:0] pl;
    logic [15:0] ph;
    logic [15:0] ctl;
  } arm_vec_t;
  arm_vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ci, k;
    vecs[0] = '{32'h0001_86A0, 1'b1, 16'h86A0, 16'h0001, 16'h0007};
    vecs[1] = '{32'h1234_5678, 1'b0, 16'h5678, 16'h1234, 16'h0005};
    vecs[2] = '{32'hFFFF_0000, 1'b1, 16'h0000, 16'hFFFF, 16'h0007};
    vecs[3] = '{32'h0000_FFFF, 1'b0, 16'hFFFF, 16'h0000, 16'h0005};

    reset_n = 1'b0;
    step(3);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_snap_valid", 32'(snap_valid), 32'd0);
    check("rst_snap_value", snap_value, 32'd0);
    check("rst_snap_elapsed", snap_elapsed, 32'd0);
    check("rst_av_address", 32'(av_address), 32'd0);
    check("rst_av_cs", 32'(av_chipselect), 32'd0);
    check("rst_av_write_n", 32'(av_write_n), 32'd1);
    check("rst_av_wdata", 32'(av_writedata), 32'd0);
    reset_n = 1'b1;
    step(2);

    for (int i = 0; i < 4; i++) begin
      do_arm(vecs[i].period, vecs[i].cont, vecs[i].pl, vecs[i].ph, vecs[i].ctl, c0);
      check("arm_ready_low", 32'(ready), 32'd0);
      step(2);
      check("arm_running_early", 32'(running), 32'd0);
      step(1);
      check("arm_running", 32'(running), 32'd1);
      check("arm_ready_back", 32'(ready), 32'd1);
      check("arm_tick_count", 32'(tick_count), 32'd0);
      do_stop();
      step(1);
      check("stop_running", 32'(running), 32'd0);
      check("stop_ready", 32'(ready), 32'd1);
      check("arm_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // Continuous, period 9: a tick every 10 cycles.
    tick_q.delete();
    do_arm(32'd9, 1'b1, 16'd9, 16'd0, 16'h0007, c0);
    for (int i = 0; i < 5; i++) push_wr(-1, STATUS, 16'h0000);
    k = 0;
    while (tick_count != TW'(5) && k < 120) begin step(1); k++; end
    check("cont_wait_tick5", (k < 120) ? 32'd1 : 32'd0, 32'd1);
    check("cont_tick_count", 32'(tick_count), 32'd5);
    step(2);
    check("cont_tick_pulses", 32'(tick_q.size()), 32'd5);
    if (tick_q.size() == 5) begin
      check("cont_first_tick", tick_q[0], c0 + 15);
      for (int i = 1; i < 5; i++) check("cont_tick_interval", tick_q[i] - tick_q[i-1], 32'd10);
    end
    check("cont_running", 32'(running), 32'd1);
    do_stop();
    step(2);
    check("cont_stop_running", 32'(running), 32'd0);
    check("cont_sb_empty", 32'(exp_q.size()), 32'd0);

    // One-shot, period 4: exactly one tick, then idle.
    tick_q.delete();
    do_arm(32'd4, 1'b0, 16'd4, 16'd0, 16'h0005, c0);
    push_wr(c0 + 10, STATUS, 16'h0000);
    step(30);
    check("oneshot_ticks", 32'(tick_q.size()), 32'd1);
    if (tick_q.size() > 0) check("oneshot_tick_cycle", tick_q[0], c0 + 10);
    check("oneshot_tick_count", 32'(tick_count), 32'd1);
    check("oneshot_running", 32'(running), 32'd0);
    check("oneshot_ready", 32'(ready), 32'd1);
    check("oneshot_sb_empty", 32'(exp_q.size()), 32'd0);

    // Snapshot 3 cycles after running rises; an early snap while busy is dropped.
    snap_seen = 0;
    do_arm(32'd100, 1'b1, 16'd100, 16'd0, 16'h0007, c0);
    cmd_snap = 1'b1;
    step(1);
    cmd_snap = 1'b0;
    step(5);
    ci = cyc_n;
    push_wr(ci + 1, SNAP_L, 16'h0000);
    cmd_snap = 1'b1;
    step(1);
    cmd_snap = 1'b0;
    k = 0;
    while (snap_seen == 0 && k < 12) begin step(1); k++; end
    check("snap_wait", (k < 12) ? 32'd1 : 32'd0, 32'd1);
    check("snap_count", 32'(snap_seen), 32'd1);
    check("snap_cycle", snap_cyc, ci + 5);
    check("snap_value", snap_value, t_snap);
    check("snap_window", (snap_value >= 32'd95 && snap_value <= 32'd97) ? 32'd1 : 32'd0, 32'd1);
    check("snap_elapsed", snap_elapsed, 32'd100 - t_snap);
    check("snap_ready", 32'(ready), 32'd1);
    do_stop();
    step(2);
    check("snap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stop arriving in the same cycle as the IRQ: status write first, then stop.
    tick_q.delete();
    do_arm(32'd9, 1'b1, 16'd9, 16'd0, 16'h0007, c0);
    k = 0;
    while (av_irq !== 1'b1 && k < 40) begin step(1); k++; end
    check("coinc_wait_irq", (k < 40) ? 32'd1 : 32'd0, 32'd1);
    check("coinc_irq_cycle", cyc_n, c0 + 14);
    ci = cyc_n;
    push_wr(ci + 1, STATUS, 16'h0000);
    push_wr(ci + 3, CONTROL, 16'h0008);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    check("coinc_ready_low", 32'(ready), 32'd0);
    check("coinc_tick", 32'(tick), 32'd1);
    step(3);
    check("coinc_running", 32'(running), 32'd0);
    check("coinc_ready", 32'(ready), 32'd1);
    check("coinc_tick_count", 32'(tick_count), 32'd1);
    check("coinc_ticks", 32'(tick_q.size()), 32'd1);
    check("coinc_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted during the period-high write.
    do_arm(32'h1234_5678, 1'b1, 16'h5678, 16'h1234, 16'h0007, c0);
    step(1);
    check("mid_wr_ph_cs", 32'(av_chipselect), 32'd1);
    check("mid_wr_ph_addr", 32'(av_address), 32'(PERIOD_H));
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(av_chipselect), 32'd0);
    check("mid_rst_write_n", 32'(av_write_n), 32'd1);
    check("mid_rst_running", 32'(running), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step(6);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_cs", 32'(av_chipselect), 32'd0);
    check("post_rst_running", 32'(running), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
